// File: rtl/servo_pwm_ctrl.sv
// Pan/tilt servo controller: rate-limited, clamped position registers driving 50 Hz PWM.
// Position commits once per frame and loads into the PWM shadow at frame start; no backpressure.
module servo_pwm_ctrl #(
  parameter int PERIOD_CYC    = 2000000,
  parameter int PULSE_MIN_CYC = 100000,
  parameter int PULSE_MAX_CYC = 200000,
  parameter int PULSE_CTR_CYC = 150000,
  parameter int STEP_CYC      = 1000,
  parameter int CNT_W         = 21
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             servo_l,
  input  logic             servo_r,
  input  logic             servo_d,
  input  logic             servo_u,
  input  logic             home,
  output logic             SERVO_H,
  output logic             SERVO_V,
  output logic [CNT_W-1:0] pos_h,
  output logic [CNT_W-1:0] pos_v,
  output logic             frame_tick,
  output logic [1:0]       lim_h,
  output logic [1:0]       lim_v
);

  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(PERIOD_CYC - 1);
  localparam logic [CNT_W-1:0] POS_MIN     = CNT_W'(PULSE_MIN_CYC);
  localparam logic [CNT_W-1:0] POS_MAX     = CNT_W'(PULSE_MAX_CYC);
  localparam logic [CNT_W-1:0] POS_CTR     = CNT_W'(PULSE_CTR_CYC);
  localparam logic [CNT_W:0]   STEP_E      = (CNT_W+1)'(STEP_CYC);
  localparam logic [CNT_W:0]   MIN_E       = (CNT_W+1)'(PULSE_MIN_CYC);
  localparam logic [CNT_W:0]   MAX_E       = (CNT_W+1)'(PULSE_MAX_CYC);

  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] sh_h, sh_v, sh_h_nxt, sh_v_nxt;
  logic [CNT_W-1:0] pos_h_nxt, pos_v_nxt;
  logic             run;
  logic             lat_l, lat_r, lat_d, lat_u, lat_home;
  logic             eff_l, eff_r, eff_d, eff_u, eff_home;

  // One axis of the boundary update; one extra bit keeps add/subtract from wrapping before the clamp.
  function automatic logic [CNT_W-1:0] step_pos(input logic [CNT_W-1:0] pos,
                                                input logic go_home, input logic inc,
                                                input logic dec);
    logic [CNT_W:0]   up, dn;
    logic [CNT_W-1:0] res;
    up  = {1'b0, pos} + STEP_E;
    dn  = {1'b0, pos} - STEP_E;
    res = pos;
    if (go_home)          res = POS_CTR;
    else if (inc && dec)  res = pos;
    else if (inc)         res = (up > MAX_E) ? POS_MAX : up[CNT_W-1:0];
    else if (dec)         res = (dn[CNT_W] || dn < MIN_E) ? POS_MIN : dn[CNT_W-1:0];
    return res;
  endfunction

  assign frame_tick = (cnt == PERIOD_LAST);

  // A request sampled on the tick cycle itself still counts for this boundary.
  assign eff_l    = lat_l    | servo_l;
  assign eff_r    = lat_r    | servo_r;
  assign eff_d    = lat_d    | servo_d;
  assign eff_u    = lat_u    | servo_u;
  assign eff_home = lat_home | home;

  always_comb begin
    pos_h_nxt = step_pos(pos_h, eff_home, eff_r, eff_l);
    pos_v_nxt = step_pos(pos_v, eff_home, eff_u, eff_d);
    // The first edge after reset acts as a wrap so a full pulse starts immediately.
    cnt_nxt   = (!run || frame_tick) ? '0 : cnt + 1'b1;
    sh_h_nxt  = frame_tick ? pos_h_nxt : sh_h;
    sh_v_nxt  = frame_tick ? pos_v_nxt : sh_v;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt      <= '0;
      run      <= 1'b0;
      pos_h    <= POS_CTR;
      pos_v    <= POS_CTR;
      sh_h     <= POS_CTR;
      sh_v     <= POS_CTR;
      lat_l    <= 1'b0;
      lat_r    <= 1'b0;
      lat_d    <= 1'b0;
      lat_u    <= 1'b0;
      lat_home <= 1'b0;
      SERVO_H  <= 1'b0;
      SERVO_V  <= 1'b0;
      lim_h    <= 2'b00;
      lim_v    <= 2'b00;
    end else begin
      cnt      <= cnt_nxt;
      run      <= 1'b1;
      lat_l    <= eff_l    & ~frame_tick;
      lat_r    <= eff_r    & ~frame_tick;
      lat_d    <= eff_d    & ~frame_tick;
      lat_u    <= eff_u    & ~frame_tick;
      lat_home <= eff_home & ~frame_tick;
      if (frame_tick) begin
        pos_h <= pos_h_nxt;
        pos_v <= pos_v_nxt;
        lim_h <= {pos_h_nxt == POS_MAX, pos_h_nxt == POS_MIN};
        lim_v <= {pos_v_nxt == POS_MAX, pos_v_nxt == POS_MIN};
      end
      sh_h    <= sh_h_nxt;
      sh_v    <= sh_v_nxt;
      SERVO_H <= (cnt_nxt < sh_h_nxt);
      SERVO_V <= (cnt_nxt < sh_v_nxt);
    end
  end

endmodule

// File: tb/tb_servo_pwm_ctrl.sv
// Directed bench for servo_pwm_ctrl with a 100-cycle frame and a 10..20 position range.
module tb_servo_pwm_ctrl;

  localparam int PER = 100;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       servo_l = 1'b0, servo_r = 1'b0, servo_d = 1'b0, servo_u = 1'b0, home = 1'b0;
  logic       SERVO_H, SERVO_V, frame_tick;
  logic [7:0] pos_h, pos_v;
  logic [1:0] lim_h, lim_v;

  servo_pwm_ctrl #(
    .PERIOD_CYC(PER), .PULSE_MIN_CYC(10), .PULSE_MAX_CYC(20),
    .PULSE_CTR_CYC(15), .STEP_CYC(2), .CNT_W(8)
  ) dut (
    .CLK(CLK), .RST_N(RST_N),
    .servo_l(servo_l), .servo_r(servo_r), .servo_d(servo_d), .servo_u(servo_u), .home(home),
    .SERVO_H(SERVO_H), .SERVO_V(SERVO_V), .pos_h(pos_h), .pos_v(pos_v),
    .frame_tick(frame_tick), .lim_h(lim_h), .lim_v(lim_v)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       l, r, d, u, hm;
    int         at, len;
    int         eh, ev;
    logic [1:0] elh, elv;
  } vec_t;

  localparam int NV = 25;
  vec_t vecs[NV];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   prev_h  = 15;
  int   prev_v  = 15;

  function automatic vec_t mk(input logic l, input logic r, input logic d, input logic u,
                              input logic hm, input int at, input int len, input int eh,
                              input int ev, input logic [1:0] elh, input logic [1:0] elv);
    vec_t t;
    t.l = l; t.r = r; t.d = d; t.u = u; t.hm = hm;
    t.at = at; t.len = len; t.eh = eh; t.ev = ev; t.elh = elh; t.elv = elv;
    return t;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic l, input logic r, input logic d, input logic u, input logic hm);
    servo_l = l; servo_r = r; servo_d = d; servo_u = u; home = hm;
  endtask

  // Runs one whole frame from its first cycle: measures both pulses and the tick,
  // applies the vector's requests, then checks the committed state after the boundary.
  task automatic run_frame(input int idx, input vec_t v);
    int nh, nv, nt, tick_last;
    nh = 0; nv = 0; nt = 0; tick_last = 0;
    for (int k = 0; k < PER; k++) begin
      @(negedge CLK);
      nh += int'(SERVO_H);
      nv += int'(SERVO_V);
      nt += int'(frame_tick);
      if (k == PER - 1) tick_last = int'(frame_tick);
      if (k >= v.at && k < v.at + v.len) drive(v.l, v.r, v.d, v.u, v.hm);
      else                               drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    chk($sformatf("v%0d width_h", idx), nh, prev_h);
    chk($sformatf("v%0d width_v", idx), nv, prev_v);
    chk($sformatf("v%0d tick_count", idx), nt, 1);
    chk($sformatf("v%0d tick_last", idx), tick_last, 1);
    @(posedge CLK);
    #1;
    chk($sformatf("v%0d pos_h", idx), int'(pos_h), v.eh);
    chk($sformatf("v%0d pos_v", idx), int'(pos_v), v.ev);
    chk($sformatf("v%0d lim_h", idx), int'(lim_h), int'(v.elh));
    chk($sformatf("v%0d lim_v", idx), int'(lim_v), int'(v.elv));
    prev_h = v.eh;
    prev_v = v.ev;
  endtask

  initial begin
    //            l  r  d  u  hm  at  len  eh  ev  lim_h  lim_v
    vecs[0]  = mk(0, 0, 0, 0, 0, 30,   0, 15, 15, 2'b00, 2'b00);
    vecs[1]  = mk(0, 1, 0, 0, 0, 30,   1, 17, 15, 2'b00, 2'b00);
    vecs[2]  = mk(0, 0, 0, 1, 0,  0, 100, 17, 17, 2'b00, 2'b00);
    vecs[3]  = mk(0, 0, 0, 1, 0,  0, 100, 17, 19, 2'b00, 2'b00);
    vecs[4]  = mk(0, 0, 0, 1, 0,  0, 100, 17, 20, 2'b00, 2'b10);
    vecs[5]  = mk(0, 0, 0, 1, 0,  0, 100, 17, 20, 2'b00, 2'b10);
    vecs[6]  = mk(0, 0, 0, 1, 0,  0, 100, 17, 20, 2'b00, 2'b10);
    vecs[7]  = mk(1, 1, 0, 0, 0, 30,   1, 17, 20, 2'b00, 2'b10);
    vecs[8]  = mk(1, 0, 0, 0, 0, 40,   5, 15, 20, 2'b00, 2'b10);
    vecs[9]  = mk(0, 0, 1, 0, 0,  0, 100, 15, 18, 2'b00, 2'b00);
    vecs[10] = mk(0, 0, 1, 0, 0,  0, 100, 15, 16, 2'b00, 2'b00);
    vecs[11] = mk(0, 0, 1, 0, 0,  0, 100, 15, 14, 2'b00, 2'b00);
    vecs[12] = mk(0, 0, 1, 0, 0,  0, 100, 15, 12, 2'b00, 2'b00);
    vecs[13] = mk(0, 0, 1, 0, 0,  0, 100, 15, 10, 2'b00, 2'b01);
    vecs[14] = mk(0, 0, 1, 0, 0,  0, 100, 15, 10, 2'b00, 2'b01);
    vecs[15] = mk(0, 0, 1, 0, 1, 30,   1, 15, 15, 2'b00, 2'b00);
    vecs[16] = mk(0, 1, 0, 0, 0, 99,   1, 17, 15, 2'b00, 2'b00);
    vecs[17] = mk(0, 0, 0, 0, 0, 30,   0, 17, 15, 2'b00, 2'b00);
    vecs[18] = mk(1, 0, 0, 0, 0,  0, 100, 15, 15, 2'b00, 2'b00);
    vecs[19] = mk(1, 0, 0, 0, 0,  0, 100, 13, 15, 2'b00, 2'b00);
    vecs[20] = mk(1, 0, 0, 0, 0,  0, 100, 11, 15, 2'b00, 2'b00);
    vecs[21] = mk(1, 0, 0, 0, 0,  0, 100, 10, 15, 2'b01, 2'b00);
    vecs[22] = mk(0, 0, 0, 0, 1, 50,   1, 15, 15, 2'b00, 2'b00);
    vecs[23] = mk(0, 0, 1, 1, 0, 30,   1, 15, 15, 2'b00, 2'b00);
    vecs[24] = mk(0, 1, 0, 0, 0, 30,   1, 17, 15, 2'b00, 2'b00);

    repeat (3) @(negedge CLK);
    chk("rst SERVO_H", int'(SERVO_H), 0);
    chk("rst SERVO_V", int'(SERVO_V), 0);
    chk("rst frame_tick", int'(frame_tick), 0);
    chk("rst pos_h", int'(pos_h), 15);
    chk("rst pos_v", int'(pos_v), 15);
    chk("rst lim_h", int'(lim_h), 0);
    chk("rst lim_v", int'(lim_v), 0);
    RST_N = 1'b1;

    for (int i = 0; i < NV; i++) run_frame(i, vecs[i]);

    // Reset in the middle of a 17-cycle pulse must cut it without a clock edge.
    for (int k = 0; k < 8; k++) @(negedge CLK);
    chk("mid pulse high", int'(SERVO_H), 1);
    #2 RST_N = 1'b0;
    #1;
    chk("async SERVO_H", int'(SERVO_H), 0);
    chk("async SERVO_V", int'(SERVO_V), 0);
    chk("async pos_h", int'(pos_h), 15);
    @(negedge CLK);
    RST_N = 1'b1;
    prev_h = 15;
    prev_v = 15;
    run_frame(100, mk(0, 0, 0, 0, 0, 30, 0, 15, 15, 2'b00, 2'b00));

    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
